vscale_htif_tohost_monitor: RTL and testbench
=============================================

# vscale_htif_tohost_monitor

Synthesizable HTIF host-side poller that sits directly on the `vscale_sim_top` HTIF PCR port. It repeatedly issues read requests to the `tohost` CSR, consumes the responses and decodes the riscv-tests exit protocol: 1 means pass; any other nonzero value means fail with code `value>>1`. It also enforces a cycle timeout. Its flags replace ad hoc polling in benches and can drive FPGA status LEDs.

## Interface
- `PCR_WIDTH`, 64: HTIF PCR data width.
- `ADDR_WIDTH`, 12: CSR address width.
- `TOHOST_ADDR`, 12'h780: CSR address polled.
- `POLL_GAP`, 4: idle cycles between a zero response and the next request. 0 means back-to-back.
- `MAX_CYCLES`, 100000: active-cycle timeout. 0 disables it.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  start polling; sampled only in IDLE.
- `htif_pcr_req_valid`  out  1  request valid.
- `htif_pcr_req_ready`  in  1  DUT accepts request.
- `htif_pcr_req_rw`  out  1  constant 0 (read).
- `htif_pcr_req_addr`  out  ADDR_WIDTH  constant TOHOST_ADDR.
- `htif_pcr_req_data`  out  PCR_WIDTH  constant 0.
- `htif_pcr_resp_valid`  in  1  response valid.
- `htif_pcr_resp_ready`  out  1  monitor accepts response.
- `htif_pcr_resp_data`  in  PCR_WIDTH  tohost value.
- `done`  out  1  sticky; set when any terminal outcome occurs.
- `pass`  out  1  sticky; tohost read as 1.
- `fail`  out  1  sticky; tohost read as nonzero and not 1.
- `timeout`  out  1  sticky; MAX_CYCLES elapsed with no terminal response.
- `fail_code`  out  PCR_WIDTH-1  `resp_data[PCR_WIDTH-1:1]` captured on fail.
- `cycle_count`  out  64  active cycles since leaving IDLE.
- `poll_count`  out  32  completed request handshakes.

## Operation
- States: IDLE, REQ, RESP, GAP, DONE.
- IDLE
  - `enable`=1 → REQ.
  - Otherwise stay.
- REQ
  - `req_valid`=1.
  - `req_valid`=1 and `req_ready`=1 at an edge → RESP, and `poll_count` increments (wraps at 2^32).
- RESP
  - `resp_ready`=1; a response is accepted when `resp_valid`=1 at an edge.
  - data==0 → GAP, or REQ if POLL_GAP=0.
  - data==1 → DONE with `pass`=1.
  - Any other value → DONE with `fail`=1 and `fail_code` loaded.
- GAP
  - The down-counter loads POLL_GAP−1 on entry.
  - → REQ when the counter is 0; decrements otherwise. Exactly POLL_GAP cycles are spent in GAP.
- DONE: absorbing until reset. `req_valid`=0 and `resp_ready`=0.
- Active cycle: any cycle in REQ, RESP or GAP.
- `cycle_count`: increments on each active edge and saturates at 2^64−1.
- Timeout
  - Condition: MAX_CYCLES≠0 and `cycle_count`+1==MAX_CYCLES at an active edge.
  - Result: → DONE with `timeout`=1.
  - This applies from any active state. An outstanding request or response is abandoned.
- Simultaneous timeout and accepted nonzero response: the response wins (`pass`/`fail`), and `timeout` stays 0.
- Simultaneous timeout and accepted zero response: timeout wins.
- `enable` falling after start: ignored.
- `pass`, `fail` and `timeout` are mutually exclusive.

## Timing
- Reset (`reset`=0 at an edge)
  - State → IDLE.
  - All outputs 0, except `req_addr`=TOHOST_ADDR and constant `req_rw`/`req_data`.
  - Counters, flags and `fail_code` are cleared.
- Reset applied mid-handshake drops `req_valid`/`resp_ready` in the following cycle. The DUT must be reset together with the monitor.
- `enable` high at edge N → `req_valid` high in cycle N+1.
- Request accepted at edge N+1 → `resp_ready` high in cycle N+2.
- Response present in cycle N+2 → flags visible in cycle N+3.
- Minimum poll period with POLL_GAP=0: 2 cycles.
- `req_valid`, once asserted, stays high until the handshake completes or a timeout/reset occurs.
- No combinational path from `resp_valid` or `req_ready` to any output. All handshake outputs are decoded from registered state only.

## Test plan
- Pass after idle polls
  - Stimulus: POLL_GAP=4; responder returns 0, 0, 0, then 1 with 1-cycle latency and `req_ready` tied 1.
  - Response: `pass`=1, `done`=1, `poll_count`=4, each zero followed by exactly 4 GAP cycles, `req_valid` 0 in DONE.
- Fail code
  - Stimulus: responder returns 0x55 on the first poll.
  - Response: `fail`=1, `fail_code`=0x2A, `pass`=`timeout`=0.
- Timeout
  - Stimulus: MAX_CYCLES=20; `resp_valid` never asserted.
  - Response: `timeout`=1 in the cycle after the 20th active edge, `cycle_count`=20, `resp_ready` 0 thereafter.
- Backpressure
  - Stimulus: `req_ready` low for 5 cycles, then high; response 1.
  - Response: `req_valid` held high for all 6 cycles, `poll_count`=1, `pass`=1.
- Simultaneous events
  - Stimulus: MAX_CYCLES set so that response 3 arrives on the timeout edge.
  - Response: `fail`=1, `fail_code`=1, `timeout`=0.
  - Stimulus: repeat with response 0.
  - Response: `timeout`=1.
- Reset mid-RESP
  - Stimulus: `reset`=0 while in RESP.
  - Response: next cycle all flags and counters 0 and state IDLE. With `enable` held high after reset is released, polling restarts one cycle later.

Source files
------------

// File: rtl/vscale_htif_tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module  : vscale_htif_tohost_monitor
// Brief   : Polls the tohost CSR over HTIF and decodes the riscv-tests exit
//           protocol into sticky pass/fail/timeout flags.
// Revision: 1.0 - initial release
// ============================================================================
module vscale_htif_tohost_monitor #(
    parameter int unsigned                PCR_WIDTH   = 64,
    parameter int unsigned                ADDR_WIDTH  = 12,
    parameter logic [ADDR_WIDTH-1:0]      TOHOST_ADDR = 12'h780,
    parameter int unsigned                POLL_GAP    = 4,
    parameter logic [63:0]                MAX_CYCLES  = 64'd100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   htif_pcr_req_valid,
    input  logic                   htif_pcr_req_ready,
    output logic                   htif_pcr_req_rw,
    output logic [ADDR_WIDTH-1:0]  htif_pcr_req_addr,
    output logic [PCR_WIDTH-1:0]   htif_pcr_req_data,
    input  logic                   htif_pcr_resp_valid,
    output logic                   htif_pcr_resp_ready,
    input  logic [PCR_WIDTH-1:0]   htif_pcr_resp_data,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [PCR_WIDTH-2:0]   fail_code,
    output logic [63:0]            cycle_count,
    output logic [31:0]            poll_count
);

    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 timeout_q, timeout_d;
    logic [PCR_WIDTH-2:0] fail_code_q, fail_code_d;
    logic [63:0]          cycle_count_q, cycle_count_d;
    logic [31:0]          poll_count_q, poll_count_d;

    logic w_active;
    logic w_tmo_hit;
    logic w_resp_term;

    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        fail_code_d   = fail_code_q;
        cycle_count_d = cycle_count_q;
        poll_count_d  = poll_count_q;

        w_active  = (state_q == S_REQ) || (state_q == S_RESP) || (state_q == S_GAP);
        // Widened compare so a saturated counter can never alias a small limit.
        w_tmo_hit = (MAX_CYCLES != 64'd0) && w_active &&
                    (({1'b0, cycle_count_q} + 65'd1) == {1'b0, MAX_CYCLES});
        w_resp_term = htif_pcr_resp_valid && (htif_pcr_resp_data != '0);

        if (w_active && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + 64'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (htif_pcr_req_ready) begin
                    poll_count_d = poll_count_q + 32'd1;
                    state_d      = S_RESP;
                end
                if (w_tmo_hit) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            S_RESP: begin
                // A terminal response beats a coincident timeout; a zero one does not.
                if (w_resp_term) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (htif_pcr_resp_data == PCR_WIDTH'(1)) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d      = 1'b1;
                        fail_code_d = htif_pcr_resp_data[PCR_WIDTH-1:1];
                    end
                end else if (w_tmo_hit) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (htif_pcr_resp_valid) begin
                    if (POLL_GAP == 0) begin
                        state_d = S_REQ;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (w_tmo_hit) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            gap_cnt_q     <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_code_q   <= '0;
            cycle_count_q <= '0;
            poll_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            fail_code_q   <= fail_code_d;
            cycle_count_q <= cycle_count_d;
            poll_count_q  <= poll_count_d;
        end
    end

    assign htif_pcr_req_valid  = (state_q == S_REQ);
    assign htif_pcr_resp_ready = (state_q == S_RESP);
    assign htif_pcr_req_rw     = 1'b0;
    assign htif_pcr_req_addr   = TOHOST_ADDR;
    assign htif_pcr_req_data   = '0;
    assign done                = done_q;
    assign pass                = pass_q;
    assign fail                = fail_q;
    assign timeout             = timeout_q;
    assign fail_code           = fail_code_q;
    assign cycle_count         = cycle_count_q;
    assign poll_count          = poll_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vscale_htif_tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_vscale_htif_tohost_monitor
// Brief   : Directed bench; instance A uses the default timeout, instance B a
//           20-cycle timeout for the timeout and coincident-event scenarios.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vscale_htif_tohost_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable_a = 1'b0;
    logic        enable_b = 1'b0;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [63:0] resp_data = '0;

    logic        a_req_valid, a_req_rw, a_resp_ready, a_done, a_pass, a_fail, a_timeout;
    logic [11:0] a_req_addr;
    logic [63:0] a_req_data, a_cycle_count;
    logic [62:0] a_fail_code;
    logic [31:0] a_poll_count;

    logic        b_req_valid, b_req_rw, b_resp_ready, b_done, b_pass, b_fail, b_timeout;
    logic [11:0] b_req_addr;
    logic [63:0] b_req_data, b_cycle_count;
    logic [62:0] b_fail_code;
    logic [31:0] b_poll_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vscale_htif_tohost_monitor #(.POLL_GAP(4)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable_a),
        .htif_pcr_req_valid(a_req_valid), .htif_pcr_req_ready(req_ready),
        .htif_pcr_req_rw(a_req_rw), .htif_pcr_req_addr(a_req_addr),
        .htif_pcr_req_data(a_req_data), .htif_pcr_resp_valid(resp_valid),
        .htif_pcr_resp_ready(a_resp_ready), .htif_pcr_resp_data(resp_data),
        .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
        .fail_code(a_fail_code), .cycle_count(a_cycle_count), .poll_count(a_poll_count)
    );

    vscale_htif_tohost_monitor #(.POLL_GAP(4), .MAX_CYCLES(64'd20)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable_b),
        .htif_pcr_req_valid(b_req_valid), .htif_pcr_req_ready(req_ready),
        .htif_pcr_req_rw(b_req_rw), .htif_pcr_req_addr(b_req_addr),
        .htif_pcr_req_data(b_req_data), .htif_pcr_resp_valid(resp_valid),
        .htif_pcr_resp_ready(b_resp_ready), .htif_pcr_resp_data(resp_data),
        .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
        .fail_code(b_fail_code), .cycle_count(b_cycle_count), .poll_count(b_poll_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_req_valid", 64'(a_req_valid), 64'd0);
        chk("rst_resp_ready", 64'(a_resp_ready), 64'd0);
        chk("rst_flags", {60'd0, a_done, a_pass, a_fail, a_timeout}, 64'd0);
        chk("rst_addr", 64'(a_req_addr), 64'h780);
        chk("rst_rw_data", a_req_data | 64'(a_req_rw), 64'd0);
        chk("rst_counts", a_cycle_count | 64'(a_poll_count), 64'd0);

        // Pass after three zero polls, 1-cycle response latency
        req_ready = 1'b1;
        enable_a  = 1'b1;
        tick();
        enable_a  = 1'b0;
        for (int p = 0; p < 4; p++) begin
            chk("p1_req_valid", 64'(a_req_valid), 64'd1);
            tick();
            chk("p1_resp_ready", 64'(a_resp_ready), 64'd1);
            tick();
            resp_valid = 1'b1;
            resp_data  = (p == 3) ? 64'd1 : 64'd0;
            tick();
            resp_valid = 1'b0;
            if (p < 3) begin
                for (int g = 0; g < 4; g++) begin
                    chk("p1_gap_idle", {62'd0, a_req_valid, a_resp_ready}, 64'd0);
                    tick();
                end
            end
        end
        chk("p1_pass", 64'(a_pass), 64'd1);
        chk("p1_done", 64'(a_done), 64'd1);
        chk("p1_fail_tmo", {62'd0, a_fail, a_timeout}, 64'd0);
        chk("p1_poll_count", 64'(a_poll_count), 64'd4);
        chk("p1_cycle_count", a_cycle_count, 64'd24);
        chk("p1_done_req_valid", 64'(a_req_valid), 64'd0);

        // Fail code on first poll
        do_reset();
        chk("p2_rst_pass", 64'(a_pass), 64'd0);
        enable_a = 1'b1;
        tick();
        enable_a = 1'b0;
        tick();
        resp_valid = 1'b1;
        resp_data  = 64'h55;
        tick();
        resp_valid = 1'b0;
        chk("p2_fail", 64'(a_fail), 64'd1);
        chk("p2_fail_code", 64'(a_fail_code), 64'h2A);
        chk("p2_pass_tmo", {62'd0, a_pass, a_timeout}, 64'd0);
        chk("p2_done", 64'(a_done), 64'd1);

        // Timeout with no response
        do_reset();
        resp_data = 64'd0;
        enable_b  = 1'b1;
        tick();
        enable_b  = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        chk("p3_tmo_early", 64'(b_timeout), 64'd0);
        chk("p3_resp_ready_pre", 64'(b_resp_ready), 64'd1);
        tick();
        chk("p3_timeout", 64'(b_timeout), 64'd1);
        chk("p3_cycle_count", b_cycle_count, 64'd20);
        chk("p3_done", 64'(b_done), 64'd1);
        chk("p3_resp_ready", 64'(b_resp_ready), 64'd0);
        tick();
        chk("p3_resp_ready_after", 64'(b_resp_ready), 64'd0);

        // Backpressure on the request channel
        do_reset();
        req_ready = 1'b0;
        enable_a  = 1'b1;
        tick();
        enable_a  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("p4_hold", 64'(a_req_valid), 64'd1);
            tick();
        end
        req_ready = 1'b1;
        chk("p4_hold6", 64'(a_req_valid), 64'd1);
        tick();
        chk("p4_poll_count", 64'(a_poll_count), 64'd1);
        resp_valid = 1'b1;
        resp_data  = 64'd1;
        tick();
        resp_valid = 1'b0;
        chk("p4_pass", 64'(a_pass), 64'd1);

        // Terminal response coincident with the timeout edge (3 then 0)
        for (int r = 0; r < 2; r++) begin
            do_reset();
            enable_b = 1'b1;
            tick();
            enable_b = 1'b0;
            for (int p = 0; p < 4; p++) begin
                tick();
                resp_valid = 1'b1;
                resp_data  = (p == 3 && r == 0) ? 64'd3 : 64'd0;
                tick();
                resp_valid = 1'b0;
                if (p < 3) begin
                    for (int g = 0; g < 4; g++) tick();
                end
            end
            if (r == 0) begin
                chk("p5_fail", 64'(b_fail), 64'd1);
                chk("p5_fail_code", 64'(b_fail_code), 64'd1);
                chk("p5_timeout", 64'(b_timeout), 64'd0);
            end else begin
                chk("p5z_timeout", 64'(b_timeout), 64'd1);
                chk("p5z_pass_fail", {62'd0, b_pass, b_fail}, 64'd0);
            end
            chk("p5_cycle_count", b_cycle_count, 64'd20);
        end

        // Reset while in RESP, enable held high
        do_reset();
        resp_data = 64'd0;
        enable_a  = 1'b1;
        tick();
        tick();
        chk("p6_in_resp", 64'(a_resp_ready), 64'd1);
        reset = 1'b0;
        tick();
        chk("p6_handshake", {62'd0, a_req_valid, a_resp_ready}, 64'd0);
        chk("p6_counts", a_cycle_count | 64'(a_poll_count), 64'd0);
        chk("p6_flags", {60'd0, a_done, a_pass, a_fail, a_timeout}, 64'd0);
        reset = 1'b1;
        tick();
        chk("p6_restart", 64'(a_req_valid), 64'd1);
        enable_a = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
